// File: rtl/bcd_scan_display_if.sv
// Bundles the display stage's value input with its converted and scanned outputs.
// master drives value; slave is the display stage itself.
interface bcd_scan_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]    value;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic [4*DIGITS-1:0] bcd;
    logic                busy;

    modport master (output value, input an, seg, bcd, busy);
    modport slave  (input value, output an, seg, bcd, busy);
endinterface

// File: rtl/bcd_scan_display.sv
// Binary-to-BCD double-dabble converter feeding a multiplexed common-anode 7-segment scan.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
//
// state | meaning
// IDLE  | waiting for a pending request or a changed value
// SHIFT | WIDTH add-3/shift iterations on the scratch register
// LATCH | publish scratch to bcd, record the converted value
module bcd_scan_display #(
    parameter int WIDTH      = 8,
    parameter int DIGITS     = 3,
    parameter int SCAN_DIV   = 100000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    bcd_scan_display_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] value_cap, bin_sr, last_value;
    logic [BCD_W-1:0] scratch, scratch_adj, bcd_q;
    logic [CNT_W-1:0] shift_cnt;
    logic             pending, busy_q, start;

    assign start = pending || (bus.value != last_value);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (shift_cnt == '0) state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Reset discards any conversion in flight and forces a fresh one via pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending    <= 1'b1;
            busy_q     <= 1'b0;
            bcd_q      <= '0;
            scratch    <= '0;
            bin_sr     <= '0;
            value_cap  <= '0;
            last_value <= '0;
            shift_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    value_cap <= bus.value;
                    bin_sr    <= bus.value;
                    scratch   <= '0;
                    busy_q    <= 1'b1;
                    pending   <= 1'b0;
                    shift_cnt <= CNT_W'(WIDTH - 1);
                end
                SHIFT: begin
                    {scratch, bin_sr} <= {scratch_adj, bin_sr} << 1;
                    shift_cnt         <= shift_cnt - CNT_W'(1);
                end
                LATCH: begin
                    bcd_q      <= scratch;
                    last_value <= value_cap;
                    busy_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    logic [PRE_W-1:0] pre_cnt;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else if (pre_cnt == PRE_W'(SCAN_DIV - 1)) begin
            pre_cnt <= '0;
            idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    logic [3:0]        digit;
    logic              blank;
    logic [DIGITS-1:0] an_raw;
    logic [6:0]        seg_raw;
`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lz_mask;
    logic              hi_zero;

    always_comb begin
        hi_zero = 1'b1;
        lz_mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero    = hi_zero && (bcd_q[4*i +: 4] == 4'd0);
            lz_mask[i] = hi_zero && (i != 0);
        end
    end
`endif

    always_comb begin
        digit  = 4'd0;
        blank  = 1'b0;
        an_raw = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                digit = bcd_q[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                blank = lz_mask[i];
`endif
                an_raw[i] = 1'b1;
            end
        end
        if (blank) an_raw = '0;
        seg_raw = blank ? 7'h00 : decode(digit);
    end

    logic [DIGITS-1:0] an_q;
    logic [6:0]        seg_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q  <= {DIGITS{ACTIVE_LOW}};
            seg_q <= {7{ACTIVE_LOW}};
        end else begin
            an_q  <= ACTIVE_LOW ? ~an_raw : an_raw;
            seg_q <= ACTIVE_LOW ? ~seg_raw : seg_raw;
        end
    end

    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.bcd  = bcd_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: conversion latency, value skipping, resets and scan order.
module tb_bcd_scan_display;
    localparam int WIDTH    = 8;
    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bcd_scan_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bcd_scan_display #(
        .WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [6:0] seg_lit(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic bit is_blank(input int v, input int slot);
`ifdef LEADING_ZERO_BLANK_EN
        return (slot > 0) && (v < pow10(slot));
`else
        return (v < 0) && (slot < 0);
`endif
    endfunction

    function automatic logic [2:0] exp_an(input int v, input int slot);
        logic [2:0] one = 3'b001;
        if (is_blank(v, slot)) return 3'b111;
        return ~(one << slot);
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int slot);
        if (is_blank(v, slot)) return 7'h7F;
        return ~seg_lit((v / pow10(slot)) % 10);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst_n     = 1'b0;
        bus.value = '0;
        repeat (3) step();
        n_cmp++; if (bus.an !== 3'b111)  begin n_err++; $display("FAIL reset_an got %b want 111", bus.an); end
        n_cmp++; if (bus.seg !== 7'h7F)  begin n_err++; $display("FAIL reset_seg got %h want 7f", bus.seg); end
        n_cmp++; if (bus.busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.bcd !== 12'h000) begin n_err++; $display("FAIL reset_bcd got %h want 000", bus.bcd); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL first_conv_start got %b want 1", bus.busy); end
        n = 1;
        while (bus.busy === 1'b1 && n < 50) begin
            step();
            if (bus.busy === 1'b1) n++;
        end
        n_cmp++; if (n != 9) begin n_err++; $display("FAIL first_conv_busy_len got %0d want 9", n); end
        n_cmp++; if (bus.bcd !== 12'h000) begin n_err++; $display("FAIL first_conv_bcd got %h want 000", bus.bcd); end
    endtask

    task automatic test_full_scale();
        int n, bad;
        bus.value = 8'd255;
        step();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL fs_start got %b want 1", bus.busy); end
        n   = 1;
        bad = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            if (bus.bcd !== 12'h000) bad++;
            step();
            if (bus.busy === 1'b1) n++;
        end
        n_cmp++; if (n != 9)   begin n_err++; $display("FAIL fs_busy_len got %0d want 9", n); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL fs_no_glitch got %0d glitches want 0", bad); end
        n_cmp++; if (bus.bcd !== to_bcd(255)) begin n_err++; $display("FAIL fs_bcd got %h want %h", bus.bcd, to_bcd(255)); end
    endtask

    task automatic test_skip();
        int n, k, bad;
        bus.value = 8'd17;
        step();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL skip_start got %b want 1", bus.busy); end
        repeat (3) step();
        bus.value = 8'd200;
        n = 4;
        while (bus.busy === 1'b1 && n < 50) begin
            step();
            if (bus.busy === 1'b1) n++;
        end
        n_cmp++; if (n != 9) begin n_err++; $display("FAIL skip_busy_len got %0d want 9", n); end
        n_cmp++; if (bus.bcd !== to_bcd(17)) begin n_err++; $display("FAIL skip_first_bcd got %h want %h", bus.bcd, to_bcd(17)); end
        k   = 0;
        bad = 0;
        while (bus.bcd !== to_bcd(200) && k < 50) begin
            if (bus.bcd !== to_bcd(17)) bad++;
            step();
            k++;
        end
        n_cmp++; if (k != 10)  begin n_err++; $display("FAIL skip_second_delay got %0d want 10", k); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL skip_hold got %0d bad samples want 0", bad); end
    endtask

    task automatic test_scan(input int v);
        int t;
        logic [2:0] prev;
        bus.value = WIDTH'(v);
        repeat (25) step();
        n_cmp++; if (bus.bcd !== to_bcd(v)) begin n_err++; $display("FAIL scan_bcd v=%0d got %h want %h", v, bus.bcd, to_bcd(v)); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL scan_busy v=%0d got %b want 0", v, bus.busy); end
        prev = bus.an;
        t    = 0;
        while (!(bus.an === 3'b110 && prev !== 3'b110) && t < 40) begin
            prev = bus.an;
            step();
            t++;
        end
        n_cmp++; if (t >= 40) begin n_err++; $display("FAIL scan_sync v=%0d got timeout want slot0 start", v); end
        for (int c = 0; c < 6 * SCAN_DIV; c++) begin
            int slot = (c / SCAN_DIV) % DIGITS;
            n_cmp++;
            if (bus.an !== exp_an(v, slot)) begin
                n_err++; $display("FAIL scan_an v=%0d c=%0d got %b want %b", v, c, bus.an, exp_an(v, slot));
            end
            n_cmp++;
            if (bus.seg !== exp_seg(v, slot)) begin
                n_err++; $display("FAIL scan_seg v=%0d c=%0d got %b want %b", v, c, bus.seg, exp_seg(v, slot));
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bus.value = 8'd99;
        step();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rm_start got %b want 1", bus.busy); end
        repeat (3) step();
        rst_n = 1'b0;
        step();
        n_cmp++; if (bus.bcd !== 12'h000) begin n_err++; $display("FAIL rm_bcd got %h want 000", bus.bcd); end
        n_cmp++; if (bus.busy !== 1'b0)  begin n_err++; $display("FAIL rm_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.an !== 3'b111)  begin n_err++; $display("FAIL rm_an got %b want 111", bus.an); end
        n_cmp++; if (bus.seg !== 7'h7F)  begin n_err++; $display("FAIL rm_seg got %h want 7f", bus.seg); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rm_restart got %b want 1", bus.busy); end
        n = 1;
        while (bus.busy === 1'b1 && n < 50) begin
            step();
            if (bus.busy === 1'b1) n++;
        end
        n_cmp++; if (n != 9) begin n_err++; $display("FAIL rm_busy_len got %0d want 9", n); end
        n_cmp++; if (bus.bcd !== to_bcd(99)) begin n_err++; $display("FAIL rm_final_bcd got %h want %h", bus.bcd, to_bcd(99)); end
    endtask

    task automatic test_random();
        int v, bad;
        for (int r = 0; r < 12; r++) begin
            bad = 0;
            v   = 0;
            for (int c = 0; c < int'($urandom_range(1, 4)); c++) begin
                v = int'($urandom_range(0, 255));
                bus.value = WIDTH'(v);
                for (int w = 0; w < int'($urandom_range(0, 12)); w++) begin
                    step();
                    if (bus.bcd[3:0] > 4'd9 || bus.bcd[7:4] > 4'd9 || bus.bcd[11:8] > 4'd2) bad++;
                end
            end
            repeat (25) step();
            n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rand_valid r=%0d got %0d bad samples want 0", r, bad); end
            n_cmp++; if (bus.bcd !== to_bcd(v)) begin n_err++; $display("FAIL rand_bcd r=%0d got %h want %h", r, bus.bcd, to_bcd(v)); end
            n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rand_busy r=%0d got %b want 0", r, bus.busy); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.value = '0;
        test_reset();
        test_full_scale();
        test_skip();
        test_scan(127);
        test_scan(5);
        test_reset_mid();
        test_random();
        for (int i = 0; i < 3; i++) test_scan(int'($urandom_range(0, 255)));
        test_scan(0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
